// File: rtl/jram_sequencer.sv
// jRAM bus initiator: sequences MAR-load, strobe and enable phases for single/burst host requests.
// Optional write read-back verify enabled by defining JRAM_SEQ_VERIFY_EN.
//
// state  | meaning
// IDLE   | ready for a host request
// ADDR   | bas driven, wsa pulsed to load the MAR
// HOLD   | MAR settle, bas held
// DATA   | ws (write) or we (read) held STROBE_CYCLES cycles
// VADDR  | verify gap after a write strobe, MAR unchanged
// VREAD  | verify read-back, we held STROBE_CYCLES cycles
// RECOV  | strobes low, response pulse, advance address/count
module jram_sequencer #(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_last,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] bas,
    output logic          wsa,
    output logic [DW-1:0] bis,
    output logic          ws,
    output logic          we,
    input  logic [DW-1:0] bos
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_HOLD, S_DATA, S_VADDR, S_VREAD, S_RECOV
    } state_t;

    localparam logic [3:0] STB_LOAD = 4'(STROBE_CYCLES - 1);

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [4:0]    rem_q, rem_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    stb_q, stb_d;

    logic          req_ready_q, wsa_q, ws_q, we_q, rsp_valid_q, rsp_last_q;
    logic [AW-1:0] bas_q;
    logic [DW-1:0] bis_q, rsp_rdata_q;

`ifdef JRAM_SEQ_VERIFY_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        wdata_d    = wdata_q;
        stb_d      = stb_q;
`ifdef JRAM_SEQ_VERIFY_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    cur_addr_d = req_addr;
                    rem_d      = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
                    wdata_d    = req_wdata;
                    state_d    = S_ADDR;
`ifdef JRAM_SEQ_VERIFY_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_ADDR: state_d = S_HOLD;
            S_HOLD: begin
                state_d = S_DATA;
                stb_d   = STB_LOAD;
            end
            S_DATA: begin
                if (stb_q == 4'd0) begin
`ifdef JRAM_SEQ_VERIFY_EN
                    state_d = write_q ? S_VADDR : S_RECOV;
`else
                    state_d = S_RECOV;
`endif
                end else begin
                    stb_d = stb_q - 4'd1;
                end
            end
`ifdef JRAM_SEQ_VERIFY_EN
            S_VADDR: begin
                state_d = S_VREAD;
                stb_d   = STB_LOAD;
            end
            S_VREAD: begin
                if (stb_q == 4'd0) begin
                    state_d = S_RECOV;
                    if (bos != wdata_q) err_d = 1'b1;
                end else begin
                    stb_d = stb_q - 4'd1;
                end
            end
`endif
            S_RECOV: begin
                rem_d      = rem_q - 5'd1;
                cur_addr_d = cur_addr_q + 1'b1;
                state_d    = (rem_q == 5'd1) ? S_IDLE : S_ADDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so every RAM-side pin comes straight off a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            wdata_q     <= '0;
            stb_q       <= '0;
            req_ready_q <= 1'b1;
            wsa_q       <= 1'b0;
            ws_q        <= 1'b0;
            we_q        <= 1'b0;
            bas_q       <= '0;
            bis_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            wdata_q     <= wdata_d;
            stb_q       <= stb_d;
            req_ready_q <= (state_d == S_IDLE);
            wsa_q       <= (state_d == S_ADDR);
            ws_q        <= (state_d == S_DATA) && write_d;
            we_q        <= ((state_d == S_DATA) && !write_d) || (state_d == S_VREAD);
            rsp_valid_q <= (state_d == S_RECOV);
            rsp_last_q  <= (state_d == S_RECOV) && (rem_d == 5'd1);
            if (state_d == S_ADDR) begin
                bas_q <= cur_addr_d;
                bis_q <= write_d ? wdata_d : '0;
            end
            if (state_d == S_RECOV) rsp_rdata_q <= write_q ? '0 : bos;
        end
    end

`ifdef JRAM_SEQ_VERIFY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = req_ready_q;
    assign wsa       = wsa_q;
    assign ws        = ws_q;
    assign we        = we_q;
    assign bas       = bas_q;
    assign bis       = bis_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_jram_sequencer.sv
// Bench for jram_sequencer: MAR-based RAM model, response scoreboard and bus invariant monitor.
module tb_jram_sequencer;

    localparam int SC = 1;
`ifdef JRAM_SEQ_VERIFY_EN
    localparam int WLAT = 4 + 2 * SC;
`else
    localparam int WLAT = 3 + SC;
`endif
    localparam int RLAT = 3 + SC;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [7:0] req_addr = '0, req_wdata = '0;
    logic [3:0] req_len = '0;
    logic       req_ready, rsp_valid, rsp_last, rsp_err, wsa, ws, we;
    logic [7:0] rsp_rdata, bas, bis, bos;

    jram_sequencer #(.AW(8), .DW(8), .STROBE_CYCLES(SC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bas(bas), .wsa(wsa), .bis(bis), .ws(ws), .we(we), .bos(bos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // RAM model: MAR loads on wsa, write on ws, read data follows MAR; optional bit-0 stuck-at-0.
    logic [7:0] mem [0:255];
    logic [7:0] mar = '0;
    logic       load_pat = 1'b1, stuck = 1'b0;
    always @(posedge clk) begin
        if (load_pat) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else begin
            if (wsa) mar <= bas;
            if (ws)  mem[mar] <= bis;
        end
    end
    assign bos = stuck ? (mem[mar] & 8'hFE) : mem[mar];

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] addr_log[$];

    int errors = 0, checks = 0;
    int rsp_count = 0, first_rsp_cyc = 0, last_rsp_cyc = 0, acc_cyc = 0;
    logic [7:0] bas_ref = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            checks++;
            if (32'(wsa) + 32'(ws) + 32'(we) > 1) begin
                errors++;
                $display("FAIL strobe_excl at cyc %0d: wsa=%b ws=%b we=%b, required at most one high", cyc, wsa, ws, we);
            end
            if (wsa) begin
                bas_ref = bas;
                addr_log.push_back(bas);
            end else if (!req_ready) begin
                checks++;
                if (bas !== bas_ref) begin
                    errors++;
                    $display("FAIL bas_stable at cyc %0d: bas=%h required %h", cyc, bas, bas_ref);
                end
            end
            if (rsp_valid) begin
                rsp_count++;
                last_rsp_cyc = cyc;
                if (rsp_count == 1) first_rsp_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp at cyc %0d: rdata=%h, required no response", cyc, rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata !== e.data) begin
                        errors++;
                        $display("FAIL rsp_rdata at cyc %0d: got %h required %h", cyc, rsp_rdata, e.data);
                    end
                    checks++;
                    if (rsp_last !== e.last) begin
                        errors++;
                        $display("FAIL rsp_last at cyc %0d: got %b required %b", cyc, rsp_last, e.last);
                    end
                end
            end
        end
    end

    function automatic void push_exp(input logic [7:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endfunction

    task automatic do_req(input logic w, input logic [7:0] a, input logic [3:0] l, input logic [7:0] d);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b, required 1 within 300 cycles", req_ready);
        end
        acc_cyc = cyc;
        rsp_count = 0;
        addr_log.delete();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++; errors++;
            $display("FAIL done_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, wsa, ws, we, rsp_valid, rsp_last, rsp_err} !== 7'b1000000 ||
            bas !== 8'h00 || bis !== 8'h00 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: ready=%b wsa=%b ws=%b we=%b v=%b l=%b e=%b bas=%h bis=%h rd=%h, required ready=1 rest 0",
                     req_ready, wsa, ws, we, rsp_valid, rsp_last, rsp_err, bas, bis, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_burst();
        int guard = 0;
        do_req(1'b1, 8'h50, 4'd3, 8'h77);
        while (!ws && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!ws) begin
            errors++;
            $display("FAIL mid_ws_seen: ws=%b required 1", ws);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ws !== 1'b0 || we !== 1'b0 || wsa !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: ws=%b we=%b wsa=%b ready=%b, required 0 0 0 1", ws, we, wsa, req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_rsp: rsp_valid=%b required 0", rsp_valid);
            end
        end
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_count !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abandon_burst: rsp_count=%0d ready=%b, required 0 and 1", rsp_count, req_ready);
        end
    endtask

    task automatic test_write_read();
        push_exp(8'h00, 1'b1);
        do_req(1'b1, 8'h10, 4'd1, 8'hA5);
        wait_done();
        checks++;
        if (first_rsp_cyc - acc_cyc !== WLAT) begin
            errors++;
            $display("FAIL write_latency: got %0d required %0d", first_rsp_cyc - acc_cyc, WLAT);
        end
        checks++;
        if (mem[8'h10] !== 8'hA5) begin
            errors++;
            $display("FAIL ram_write: mem[10]=%h required a5", mem[8'h10]);
        end
        push_exp(8'hA5, 1'b1);
        do_req(1'b0, 8'h10, 4'd1, 8'h00);
        wait_done();
        checks++;
        if (first_rsp_cyc - acc_cyc !== RLAT || rsp_count !== 1) begin
            errors++;
            $display("FAIL read_latency: got %0d/%0d rsp required %0d/1", first_rsp_cyc - acc_cyc, rsp_count, RLAT);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] a;
        for (int i = 0; i < 4; i++) push_exp(8'h00, i == 3);
        do_req(1'b1, 8'hFE, 4'd4, 8'h3C);
        wait_done();
        checks++;
        if (addr_log.size() !== 4 || rsp_count !== 4) begin
            errors++;
            $display("FAIL wrap_count: addrs=%0d rsp=%0d required 4 and 4", addr_log.size(), rsp_count);
        end
        for (int i = 0; i < 4; i++) begin
            a = 8'hFE + 8'(i);
            checks++;
            if (i < addr_log.size() && addr_log[i] !== a) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: got %h required %h", i, addr_log[i], a);
            end
            checks++;
            if (mem[a] !== 8'h3C) begin
                errors++;
                $display("FAIL wrap_fill[%h]: got %h required 3c", a, mem[a]);
            end
        end
        for (int i = 0; i < 4; i++) push_exp(8'h3C, i == 3);
        do_req(1'b0, 8'hFE, 4'd4, 8'h00);
        wait_done();
        checks++;
        if (rsp_count !== 4) begin
            errors++;
            $display("FAIL wrap_read_count: got %0d required 4", rsp_count);
        end
    endtask

    task automatic test_len16();
        logic [7:0] a;
        for (int i = 0; i < 16; i++) begin
            a = 8'h20 + 8'(i);
            push_exp(a ^ 8'h5A, i == 15);
        end
        do_req(1'b0, 8'h20, 4'd0, 8'h00);
        wait_done();
        checks++;
        if (rsp_count !== 16 || last_rsp_cyc - acc_cyc !== 16 * RLAT) begin
            errors++;
            $display("FAIL len16: rsp=%0d cycles=%0d required 16 and %0d", rsp_count, last_rsp_cyc - acc_cyc, 16 * RLAT);
        end
        checks++;
        if (addr_log.size() !== 16) begin
            errors++;
            $display("FAIL len16_addrs: got %0d required 16", addr_log.size());
        end
        for (int i = 0; i < 16 && i < addr_log.size(); i++) begin
            a = 8'h20 + 8'(i);
            checks++;
            if (addr_log[i] !== a) begin
                errors++;
                $display("FAIL len16_addr[%0d]: got %h required %h", i, addr_log[i], a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev_last;
        push_exp(8'hA5, 1'b0);
        push_exp(8'h11 ^ 8'h5A, 1'b1);
        do_req(1'b0, 8'h10, 4'd2, 8'h00);
        push_exp(8'h00, 1'b1);
        do_req(1'b1, 8'h40, 4'd1, 8'h99);
        prev_last = last_rsp_cyc;
        checks++;
        if (acc_cyc !== prev_last + 1) begin
            errors++;
            $display("FAIL busy_accept: accepted at %0d required %0d", acc_cyc, prev_last + 1);
        end
        wait_done();
        checks++;
        if (mem[8'h40] !== 8'h99) begin
            errors++;
            $display("FAIL b2b_write: mem[40]=%h required 99", mem[8'h40]);
        end
    endtask

    task automatic test_verify();
`ifdef JRAM_SEQ_VERIFY_EN
        stuck = 1'b1;
        push_exp(8'h00, 1'b1);
        do_req(1'b1, 8'h30, 4'd1, 8'h01);
        wait_done();
        checks++;
        if (rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL verify_err_set: rsp_err=%b required 1", rsp_err);
        end
        push_exp(8'h00, 1'b1);
        do_req(1'b0, 8'h30, 4'd1, 8'h00);
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL verify_err_clear: rsp_err=%b required 0", rsp_err);
        end
        wait_done();
        push_exp(8'h00, 1'b1);
        do_req(1'b1, 8'h31, 4'd1, 8'h02);
        wait_done();
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL verify_match: rsp_err=%b required 0", rsp_err);
        end
        stuck = 1'b0;
`else
        stuck = 1'b1;
        push_exp(8'h00, 1'b1);
        do_req(1'b1, 8'h30, 4'd1, 8'h01);
        wait_done();
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied: rsp_err=%b required 0", rsp_err);
        end
        stuck = 1'b0;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        load_pat = 1'b0;
        reset_n  = 1'b1;
        repeat (2) @(negedge clk);
        test_reset_mid_burst();
        test_write_read();
        test_wrap();
        test_len16();
        test_back_to_back();
        test_verify();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
